// File: rtl/bus_ack.sv
// 68000 bus-cycle terminator: turns mapper chip selects into DTACK after per-device
// wait states, or BERR for unmapped/unassigned space and for timeouts.
module bus_ack #(
   parameter int unsigned WS_RAM  = 2,
   parameter int unsigned WS_ROM  = 4,
   parameter int unsigned WS_IO   = 3,
   parameter int unsigned WS_CTRL = 1,
   parameter int unsigned TIMEOUT = 255
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       as_n,
   input  logic       pas,
   input  logic       csunmap,
   input  logic       csram1,
   input  logic       csram2,
   input  logic       csrom,
   input  logic       csio,
   input  logic       csgfx,
   input  logic       csctrl,
   input  logic       cspgtbl,
   input  logic       gfx_ack,
   output logic       dtack_n,
   output logic       berr_n,
   output logic       busy,
   output logic [2:0] state_o
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_DECODE  = 3'd1,
      S_WAIT    = 3'd2,
      S_EXTWAIT = 3'd3,
      S_ACK     = 3'd4,
      S_BERR    = 3'd5
   } state_t;

   localparam logic [7:0] WS_RAM_C  = 8'(WS_RAM);
   localparam logic [7:0] WS_ROM_C  = 8'(WS_ROM);
   localparam logic [7:0] WS_IO_C   = 8'(WS_IO);
   localparam logic [7:0] WS_CTRL_C = 8'(WS_CTRL);
   localparam logic [7:0] TO_LAST   = 8'(TIMEOUT - 1);

   state_t     state_q, state_d;
   logic [7:0] cnt_q, cnt_d;
   logic       as_meta_q, as_sync_q;
   logic       dtack_n_q, berr_n_q, busy_q;
   logic       as_s;

   // Handshake: as_n low opens a cycle; exactly one of dtack_n/berr_n answers it
   // and is held until the synchronized strobe negates, then the FSM idles a cycle.
   assign as_s = ~as_sync_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         as_meta_q <= 1'b1;
         as_sync_q <= 1'b1;
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         dtack_n_q <= 1'b1;
         berr_n_q  <= 1'b1;
         busy_q    <= 1'b0;
      end else begin
         as_meta_q <= as_n;
         as_sync_q <= as_meta_q;
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         dtack_n_q <= (state_d != S_ACK);
         berr_n_q  <= (state_d != S_BERR);
         busy_q    <= (state_d != S_IDLE);
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_IDLE: begin
            if (as_s) begin
               state_d = S_DECODE;
               cnt_d   = '0;
            end
         end
         S_DECODE: begin
            if (!as_s) begin
               state_d = S_IDLE;
            end else if (pas) begin
               // Priority order of the selects; no select at all is unassigned space.
               if (csunmap) begin
                  state_d = S_BERR;
               end else if (csgfx) begin
                  state_d = S_EXTWAIT;
                  cnt_d   = '0;
               end else if (csio) begin
                  state_d = S_WAIT;
                  cnt_d   = WS_IO_C;
               end else if (csctrl || cspgtbl) begin
                  state_d = S_WAIT;
                  cnt_d   = WS_CTRL_C;
               end else if (csrom) begin
                  state_d = S_WAIT;
                  cnt_d   = WS_ROM_C;
               end else if (csram1 || csram2) begin
                  state_d = S_WAIT;
                  cnt_d   = WS_RAM_C;
               end else begin
                  state_d = S_BERR;
               end
            end else if (cnt_q == TO_LAST) begin
               state_d = S_BERR;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         S_WAIT: begin
            if (!as_s) begin
               state_d = S_IDLE;
            end else if (cnt_q == 8'd0) begin
               state_d = S_ACK;
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         S_EXTWAIT: begin
            if (!as_s) begin
               state_d = S_IDLE;
            end else if (gfx_ack) begin
               state_d = S_ACK;
            end else if (cnt_q == TO_LAST) begin
               state_d = S_BERR;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         S_ACK, S_BERR: begin
            if (!as_s) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign dtack_n = dtack_n_q;
   assign berr_n  = berr_n_q;
   assign busy    = busy_q;
   assign state_o = state_q;

endmodule
